// File: rtl/seg_scan_ctrl_if.sv
//-----------------------------------------------------------------------------
// seg_scan_ctrl_if
//
// Purpose : valid/ready load channel for seg_scan_ctrl. One transfer happens on
//           each rising clock edge where load_valid and load_ready are both high.
//
// Signals :
//   load_valid  source -> ctrl  load_data is valid this cycle
//   load_ready  ctrl -> source  controller can accept a load this cycle
//   load_data   source -> ctrl  packed nibbles, bits [3:0] are digit 0
//
// Modports: master (value source), slave (seg_scan_ctrl).
//-----------------------------------------------------------------------------
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );

endinterface : seg_scan_ctrl_if

// File: rtl/seg_scan_ctrl.sv
//-----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Purpose : time-multiplexing scan controller for a common-anode, multi-digit
//           seven-segment display. It shows a packed hex value one digit at a
//           time on a shared active-low segment bus, with an active-low anode
//           select. Every digit slot is REFRESH_DIV cycles long: a dwell period
//           followed by GUARD cycles with all anodes off, which suppresses
//           ghosting. New values arrive through a valid/ready channel, wait in a
//           shadow register, and are copied to the displayed value only at a
//           frame boundary, so a frame never shows a mix of two values.
//
// Ports   :
//   clk         in   single clock, rising edge
//   rst         in   synchronous reset, active low
//   lb          if   load channel (seg_scan_ctrl_if.slave)
//   seg         out  segment bus {g,f,e,d,c,b,a}, active low, registered
//   an          out  anode enables, active low, one-hot-low or all high, registered
//   frame_tick  out  one-cycle pulse on the last cycle of each frame, registered
//
// Build option:
//   SEG_LZ_BLANK_EN  when defined, leading zeros are blanked (digit 0 never).
//
// Output timing: the outputs are registered from the counter state, so they
// trail cnt/digit by one cycle. The reset cycle shows blank, and the first
// cycle after reset is released shows cnt==0 of digit 0. frame_tick is high in
// the cycle that follows the boundary edge. That cycle is the last cycle of the
// displayed frame.
//-----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_scan_ctrl_if.slave        lb,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_tick
);

  //---------------------------------------------------------------------------
  // Derived constants
  //---------------------------------------------------------------------------
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DIG_W = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  // Parameter legality, checked at elaboration.
  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("seg_scan_ctrl: NUM_DIGITS must be 1..8");
    end
    if (GUARD < 0 || REFRESH_DIV < GUARD + 1) begin : g_bad_timing
      $error("seg_scan_ctrl: need GUARD >= 0 and REFRESH_DIV >= GUARD+1");
    end
  endgenerate

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_GUARD = 1'b1
  } state_e;

  //---------------------------------------------------------------------------
  // Hex to active-low segment pattern {g,f,e,d,c,b,a}
  //---------------------------------------------------------------------------
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'b100_0000;
      4'h1: s = 7'b111_1001;
      4'h2: s = 7'b010_0100;
      4'h3: s = 7'b011_0000;
      4'h4: s = 7'b001_1001;
      4'h5: s = 7'b001_0010;
      4'h6: s = 7'b000_0010;
      4'h7: s = 7'b111_1000;
      4'h8: s = 7'b000_0000;
      4'h9: s = 7'b001_0000;
      4'hA: s = 7'b000_1000;
      4'hB: s = 7'b000_0011;
      4'hC: s = 7'b100_0110;
      4'hD: s = 7'b010_0001;
      4'hE: s = 7'b000_0110;
      default: s = 7'b000_1110; // F
    endcase
    return s;
  endfunction

  //---------------------------------------------------------------------------
  // Registers
  //---------------------------------------------------------------------------
  state_e                  state_q,       state_d;
  logic [CNT_W-1:0]        cnt_q,         cnt_d;
  logic [DIG_W-1:0]        digit_q,       digit_d;
  logic [VAL_W-1:0]        active_q,      active_d;
  logic [VAL_W-1:0]        shadow_q,      shadow_d;
  logic                    shadow_full_q, shadow_full_d;
  logic                    run_q;         // low only in the cycle after reset
  logic [6:0]              seg_q,         seg_d;
  logic [NUM_DIGITS-1:0]   an_q,          an_d;
  logic                    frame_tick_q,  frame_tick_d;

  logic cnt_wrap;
  logic boundary;
  logic accept;
  logic lz_blank;

  //---------------------------------------------------------------------------
  // Slot counter and digit index
  //---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default at the top so that no path
  // leaves it unassigned; an unassigned path would infer a latch.
  always_comb begin
    cnt_wrap = (cnt_q == CNT_LAST);
    boundary = cnt_wrap && (digit_q == DIG_LAST);
    cnt_d    = cnt_q + CNT_W'(1);
    digit_d  = digit_q;
    if (cnt_wrap) begin
      cnt_d   = '0;
      digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DIG_W'(1);
    end
  end

  //---------------------------------------------------------------------------
  // Load handshake and frame-boundary commit
  //---------------------------------------------------------------------------
  // run_q keeps load_ready low in the cycle after reset, even when rst has
  // already returned high during that cycle.
  assign lb.load_ready = rst & run_q & ~shadow_full_q;
  assign accept        = lb.load_valid & lb.load_ready;

  always_comb begin
    active_d      = active_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    // Commit only what was already waiting. A load accepted on the boundary
    // edge finds shadow_full_q low, so it goes to shadow and waits a frame.
    if (boundary && shadow_full_q) begin
      active_d      = shadow_q;
      shadow_full_d = 1'b0;
    end
    // accept implies shadow_full_q == 0, so it never collides with a commit.
    if (accept) begin
      shadow_d      = lb.load_data;
      shadow_full_d = 1'b1;
    end
  end

  //---------------------------------------------------------------------------
  // FSM, process 1 of 3: state register (tracks cnt_q)
  //---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every flop samples
  // pre-edge values no matter how the blocks are ordered.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_SHOW;
    else      state_q <= state_d;
  end

  //---------------------------------------------------------------------------
  // FSM, process 2 of 3: next state. The state is a function of the counter.
  // With GUARD == 0 the threshold equals REFRESH_DIV, so ST_GUARD never occurs.
  //---------------------------------------------------------------------------
  always_comb begin
    state_d = ST_SHOW;
    if (int'(cnt_d) >= REFRESH_DIV - GUARD) state_d = ST_GUARD;
  end

  //---------------------------------------------------------------------------
  // Leading-zero blanking: the current digit is blank when it and every more
  // significant nibble are zero. Digit 0 always shows.
  //---------------------------------------------------------------------------
`ifdef SEG_LZ_BLANK_EN
  always_comb begin
    lz_blank = (digit_q != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(digit_q) && active_q[4*i +: 4] != 4'h0) lz_blank = 1'b0;
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  //---------------------------------------------------------------------------
  // FSM, process 3 of 3: output decode, registered below for glitch-free pins
  //---------------------------------------------------------------------------
  always_comb begin
    seg_d        = SEG_BLANK;
    an_d         = '1;
    frame_tick_d = boundary;
    unique case (state_q)
      ST_SHOW: begin
        if (!lz_blank) begin
          an_d  = ~(NUM_DIGITS'(1) << digit_q);
          seg_d = decode(active_q[4*digit_q +: 4]);
        end
      end
      default: begin
        seg_d = SEG_BLANK;
        an_d  = '1;
      end
    endcase
  end

  //---------------------------------------------------------------------------
  // Control and output registers
  //---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q         <= '0;
      digit_q       <= '0;
      active_q      <= '0;
      shadow_full_q <= 1'b0;
      run_q         <= 1'b0;
      seg_q         <= SEG_BLANK;
      an_q          <= '1;
      frame_tick_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      digit_q       <= digit_d;
      active_q      <= active_d;
      shadow_full_q <= shadow_full_d;
      run_q         <= 1'b1;
      seg_q         <= seg_d;
      an_q          <= an_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  // NOTE: shadow_q holds data only. Clearing shadow_full_q in reset is enough
  // to discard it, so this register has no reset.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule : seg_scan_ctrl
